// File: rtl/accum_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Drives a combinational ALU from registered IR/MDR/AC and writes the ALU result Z back into AC.
module accum_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic [7:0] alu_opcode,
  output logic [7:0] alu_value,
  output logic [7:0] alu_mdr,
  output logic [7:0] alu_ac,
  input  logic [7:0] alu_z,
  input  logic       alu_nflg,
  input  logic       alu_zflg,
  output logic       halted,
  output logic [7:0] ac_out
);

  typedef enum logic [2:0] {
    S_FETCH1, S_FETCH2, S_ARG, S_MEMRD, S_MDR, S_EXEC, S_HALT
  } state_t;

  localparam logic [7:0] OP_STORE = 8'h03;
  localparam logic [7:0] OP_JMP   = 8'h10;
  localparam logic [7:0] OP_JN    = 8'h11;
  localparam logic [7:0] OP_JZ    = 8'h12;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_op_q;
  logic [7:0] ir_arg_q;
  logic [7:0] mdr_q;
  logic [7:0] ac_q;
  logic       halted_q;

  function automatic logic needs_mem(input logic [7:0] op);
    case (op)
      8'h01, 8'h05, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D: needs_mem = 1'b1;
      default: needs_mem = 1'b0;
    endcase
  endfunction

  function automatic logic writes_ac(input logic [7:0] op);
    writes_ac = (op == 8'h01) || (op == 8'h02) || ((op >= 8'h04) && (op <= 8'h0F));
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH1;
      pc_q     <= RESET_PC;
      ir_op_q  <= 8'h00;
      ir_arg_q <= 8'h00;
      mdr_q    <= 8'h00;
      ac_q     <= 8'h00;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH1: state_q <= S_FETCH2;
        S_FETCH2: begin
          ir_op_q <= mem_rdata;
          pc_q    <= pc_q + 8'd2;
          state_q <= S_ARG;
        end
        S_ARG: begin
          ir_arg_q <= mem_rdata;
          state_q  <= needs_mem(ir_op_q) ? S_MEMRD : S_EXEC;
        end
        S_MEMRD: state_q <= S_MDR;
        S_MDR: begin
          mdr_q   <= mem_rdata;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH1;
          if (writes_ac(ir_op_q)) ac_q <= alu_z;
          // Jumps overwrite the PC+2 already applied during FETCH2.
          case (ir_op_q)
            OP_JMP:  pc_q <= ir_arg_q;
            OP_JN:   if (alu_nflg) pc_q <= ir_arg_q;
            OP_JZ:   if (alu_zflg) pc_q <= ir_arg_q;
            OP_HALT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH1;
      endcase
    end
  end

  always_comb begin
    mem_addr = pc_q;
    case (state_q)
      S_FETCH2: mem_addr = pc_q + 8'd1;
      S_MEMRD:  mem_addr = ir_arg_q;
      S_EXEC:   if (ir_op_q == OP_STORE) mem_addr = ir_arg_q;
      default:  ;
    endcase
  end

  assign mem_we     = (state_q == S_EXEC) && (ir_op_q == OP_STORE);
  assign mem_wdata  = ac_q;
  assign alu_opcode = ir_op_q;
  assign alu_value  = ir_arg_q;
  assign alu_mdr    = mdr_q;
  assign alu_ac     = ac_q;
  assign halted     = halted_q;
  assign ac_out     = ac_q;

endmodule
